// File: rtl/nibble_parity_tx.sv
// nibble_parity_tx: frames a 4-bit nibble as start, d0..d3, parity, stop and
// shifts it out LSB first on a single idle-high line.
// Optional build macro NIBBLE_TX_ODD_PARITY_EN selects odd parity (default even).
module nibble_parity_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       parity_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_bit_idx;
  logic [3:0]       r_shift;
  logic             r_parity;
  logic             r_ready;
  logic             w_accept;
  logic             w_bit_end;
  logic             w_par_calc;

  assign w_accept  = valid & r_ready;
  assign w_bit_end = (r_cnt == LP_CNT_LAST);

`ifdef NIBBLE_TX_ODD_PARITY_EN
  assign w_par_calc = ~^data_in;
`else
  assign w_par_calc = ^data_in;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and line/status outputs
  always_comb begin
    w_state_nxt = r_state;
    tx          = 1'b1;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        tx = r_shift[0];
        if (w_bit_end && (r_bit_idx == 2'd3)) w_state_nxt = S_PARITY;
      end
      S_PARITY: begin
        tx = r_parity;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: bit-period counter, shift register, bit index, parity, ready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      // ready mirrors the upcoming state so it rises on the edge STOP ends
      r_ready <= (w_state_nxt == S_IDLE);
      if (r_state == S_IDLE || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_shift   <= data_in;
        r_bit_idx <= '0;
        r_parity  <= w_par_calc;
      end else if (r_state == S_DATA && w_bit_end) begin
        r_shift   <= {1'b0, r_shift[3:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

  assign ready      = r_ready;
  assign parity_out = r_parity;

endmodule
